// File: rtl/debug_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_uart_pkg
// Description : Shared state encoding, oversampling constants and baud divider
//               helper for the debug UART receive/transmit paths.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int SAMPLE_MID = 8;
    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk, input int baud);
        return clk / (baud * OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : debug_uart_fifo
// Description : Show-ahead synchronous FIFO (power-of-two depth) with
//               push/pop, full/empty flags and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : debug_uart_rx
// Description : 16x oversampled UART receiver with 3-sample majority vote,
//               framing/break/overrun status and a show-ahead byte FIFO.
//               Define DEBUG_UART_RX_PARITY_EN to add a parity bit check.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_uart_rx
    import debug_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
`ifdef DEBUG_UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       break_det,
`ifdef DEBUG_UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int             DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int             TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]     S_FIRST   = 4'(SAMPLE_MID - 1);
    localparam logic [3:0]     S_MID     = 4'(SAMPLE_MID);
    localparam logic [3:0]     S_DECIDE  = 4'(SAMPLE_MID + 1);
    localparam logic [3:0]     S_LAST    = 4'(OVERSAMPLE - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_rxs_prev;
    logic            w_rxs;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick_run;
    logic            w_tick;
    logic            w_start;
    logic [3:0]      r_samp;
    logic            r_s7;
    logic            r_s8;
    logic            w_maj;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic            r_brk_wait;
    logic [3:0]      r_hi_cnt;
    logic            w_push;
    logic            w_frame_set;
    logic            w_break_set;
    logic            r_frame_err;
    logic            r_break_det;
    logic            r_overrun;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [AW:0]     w_count;
`ifdef DEBUG_UART_RX_PARITY_EN
    logic            r_par_bit;
    logic            w_par_ok;
    logic            w_parity_set;
    logic            r_parity_err;

    assign w_par_ok   = (r_par_bit == ((^r_shift) ^ (PARITY_ODD != 0)));
    assign parity_err = r_parity_err;
`endif

    assign w_rxs      = r_sync2;
    assign w_maj      = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    // Ticks also run in IDLE while waiting out a break, to time the idle-high gap.
    assign w_tick_run = (r_state != IDLE) | r_brk_wait;
    assign w_tick     = w_tick_run & (r_tick_cnt == TICK_LAST);
    assign w_start    = (r_state == IDLE) & (w_state_nxt == START);
    assign w_pop      = rx_ready & (w_count != '0);

    assign rx_valid   = ~w_empty;
    assign frame_err  = r_frame_err;
    assign break_det  = r_break_det;
    assign overrun    = r_overrun;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        w_break_set = 1'b0;
`ifdef DEBUG_UART_RX_PARITY_EN
        w_parity_set = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!r_brk_wait && r_rxs_prev && !w_rxs) w_state_nxt = START;
            end
            START: begin
                if (w_tick && r_samp == S_DECIDE && w_maj) w_state_nxt = IDLE;
                else if (w_tick && r_samp == S_LAST)       w_state_nxt = DATA;
            end
            DATA: begin
                if (w_tick && r_samp == S_LAST && r_bit_idx == 3'd7) begin
`ifdef DEBUG_UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef DEBUG_UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick && r_samp == S_LAST) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (w_tick && r_samp == S_DECIDE) begin
                    w_state_nxt = IDLE;
                    if (w_maj) begin
`ifdef DEBUG_UART_RX_PARITY_EN
                        if (w_par_ok) w_push       = 1'b1;
                        else          w_parity_set = 1'b1;
`else
                        w_push = 1'b1;
`endif
                    end else begin
                        w_frame_set = 1'b1;
                        w_break_set = (r_shift == 8'h00);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rxs_prev  <= 1'b1;
            r_tick_cnt  <= '0;
            r_samp      <= '0;
            r_s7        <= 1'b0;
            r_s8        <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_brk_wait  <= 1'b0;
            r_hi_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_break_det <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef DEBUG_UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1    <= rx_pin;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;

            if (w_start || !w_tick_run || w_tick) r_tick_cnt <= '0;
            else                                   r_tick_cnt <= r_tick_cnt + 1'b1;

            if (w_start)     r_samp <= '0;
            else if (w_tick) r_samp <= r_samp + 1'b1;

            if (w_tick && r_samp == S_FIRST) r_s7 <= w_rxs;
            if (w_tick && r_samp == S_MID)   r_s8 <= w_rxs;

            if (r_state == DATA && w_tick && r_samp == S_DECIDE) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
            if (r_state == START) begin
                r_bit_idx <= '0;
            end else if (r_state == DATA && w_tick && r_samp == S_LAST) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // After a break the line must sit high for a full bit before re-arming.
            if (w_break_set) begin
                r_brk_wait <= 1'b1;
                r_hi_cnt   <= '0;
            end else if (r_brk_wait) begin
                if (!w_rxs) begin
                    r_hi_cnt <= '0;
                end else if (w_tick) begin
                    if (r_hi_cnt == 4'hF) r_brk_wait <= 1'b0;
                    r_hi_cnt <= r_hi_cnt + 1'b1;
                end
            end

            r_frame_err <= w_frame_set;
            r_break_det <= w_break_set;
`ifdef DEBUG_UART_RX_PARITY_EN
            if (r_state == PARITY && w_tick && r_samp == S_DECIDE) r_par_bit <= w_maj;
            r_parity_err <= w_parity_set;
`endif

            if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
            else if (overrun_clr)           r_overrun <= 1'b0;
        end
    end

    debug_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (resetb),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
`default_nettype wire
